// File: rtl/mem_controller.sv
// mem_controller: shared memory controller between the miniGPU requesters
// and one external memory channel.
//
// Requests from NUM_CONSUMERS ports are arbitrated round-robin. Only one
// access is in flight at a time. Read data and completion go back to the
// requester that issued the access, using a four-phase handshake.
//
// Ports:
//   clk, reset                      clock, async active-low reset
//   consumer_read_valid/_address    per-consumer read requests (packed)
//   consumer_read_ready/_data       per-consumer read completion + data
//   consumer_write_valid/_address/_data  per-consumer write requests
//   consumer_write_ready            per-consumer write completion
//   mem_read_valid/_address         external read request
//   mem_read_ready/_data            external read response
//   mem_write_valid/_address/_data  external write request
//   mem_write_ready                 external write accepted

// Per-consumer completion state: read-ready flag, read data, write-ready flag.
module mem_ctrl_lane #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_set_i,   // capture data and raise read ready
  input  logic                 rd_clr_i,   // drop read ready
  input  logic [DATA_BITS-1:0] rd_data_i,
  input  logic                 wr_set_i,
  input  logic                 wr_clr_i,
  output logic                 rd_ready_o,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 wr_ready_o
);
  logic                 rd_ready_q;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 wr_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      if (rd_set_i) begin
        rd_ready_q <= 1'b1;
        rd_data_q  <= rd_data_i;
      end else if (rd_clr_i) begin
        rd_ready_q <= 1'b0;
      end
      if (wr_set_i)      wr_ready_q <= 1'b1;
      else if (wr_clr_i) wr_ready_q <= 1'b0;
    end
  end

  assign rd_ready_o = rd_ready_q;
  assign rd_data_o  = rd_data_q;
  assign wr_ready_o = wr_ready_q;
endmodule

module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);
  localparam int OW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_WR_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_RELAY = 3'd3;
  localparam logic [2:0] S_WR_RELAY = 3'd4;

  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] rd_addr_a, wr_addr_a;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] wr_data_a;
  assign rd_addr_a = consumer_read_address;
  assign wr_addr_a = consumer_write_address;
  assign wr_data_a = consumer_write_data;

  logic [2:0]           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 mrv_q, mrv_d;
  logic [ADDR_BITS-1:0] mra_q, mra_d;
  logic                 mwv_q, mwv_d;
  logic [ADDR_BITS-1:0] mwa_q, mwa_d;
  logic [DATA_BITS-1:0] mwd_q, mwd_d;

  logic [NUM_CONSUMERS-1:0] rd_set, rd_clr, wr_set, wr_clr;

  // Round-robin search: first requester starting just after the last owner.
  logic          gnt_found;
  logic [OW-1:0] gnt_idx;
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_CONSUMERS; off++) begin
      cand = (int'(rr_ptr_q) + off) % NUM_CONSUMERS;
      if (!gnt_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    mrv_d    = mrv_q;
    mra_d    = mra_q;
    mwv_d    = mwv_q;
    mwa_d    = mwa_q;
    mwd_d    = mwd_q;
    rd_set   = '0;
    rd_clr   = '0;
    wr_set   = '0;
    wr_clr   = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          owner_d  = gnt_idx;
          rr_ptr_d = gnt_idx;
          // Read wins when the granted consumer asks for both.
          if (consumer_read_valid[gnt_idx]) begin
            mrv_d   = 1'b1;
            mra_d   = rd_addr_a[gnt_idx];
            state_d = S_RD_WAIT;
          end else begin
            mwv_d   = 1'b1;
            mwa_d   = wr_addr_a[gnt_idx];
            mwd_d   = wr_data_a[gnt_idx];
            state_d = S_WR_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (mem_read_ready) begin
          mrv_d = 1'b0;
          // A requester that gave up early gets no completion; the access
          // itself still finishes on the memory side.
          if (consumer_read_valid[owner_q]) begin
            rd_set[owner_q] = 1'b1;
            state_d         = S_RD_RELAY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WR_WAIT: begin
        if (mem_write_ready) begin
          mwv_d = 1'b0;
          if (consumer_write_valid[owner_q]) begin
            wr_set[owner_q] = 1'b1;
            state_d         = S_WR_RELAY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RD_RELAY: begin
        if (!consumer_read_valid[owner_q]) begin
          rd_clr[owner_q] = 1'b1;
          state_d         = S_IDLE;
        end
      end
      S_WR_RELAY: begin
        if (!consumer_write_valid[owner_q]) begin
          wr_clr[owner_q] = 1'b1;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      // Last-served pointer starts at the top so consumer 0 is searched first.
      rr_ptr_q <= OW'(NUM_CONSUMERS - 1);
      mrv_q    <= 1'b0;
      mra_q    <= '0;
      mwv_q    <= 1'b0;
      mwa_q    <= '0;
      mwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      mrv_q    <= mrv_d;
      mra_q    <= mra_d;
      mwv_q    <= mwv_d;
      mwa_q    <= mwa_d;
      mwd_q    <= mwd_d;
    end
  end

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lane
    mem_ctrl_lane #(.DATA_BITS(DATA_BITS)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .rd_set_i   (rd_set[g]),
      .rd_clr_i   (rd_clr[g]),
      .rd_data_i  (mem_read_data),
      .wr_set_i   (wr_set[g]),
      .wr_clr_i   (wr_clr[g]),
      .rd_ready_o (consumer_read_ready[g]),
      .rd_data_o  (consumer_read_data[g*DATA_BITS +: DATA_BITS]),
      .wr_ready_o (consumer_write_ready[g])
    );
  end

  assign mem_read_valid    = mrv_q;
  assign mem_read_address  = mra_q;
  assign mem_write_valid   = mwv_q;
  assign mem_write_address = mwa_q;
  assign mem_write_data    = mwd_q;
endmodule
